// File: rtl/mem_write_buffer.sv
// Processor store buffer: circular FIFO of pending word writes drained one at a time
// over a req/ack port, with youngest-match load forwarding.
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state_q;
  logic [AW-1:0]   head_q, tail_q, head_d, tail_d, head_nx_s, idx_s;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic            mem_req_q, overflow_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic            push_s, pop_s, full_s;
  logic [31:0]     store_addr_s, fwd_data_s;

  assign full_s       = (count_q == CW'(DEPTH));
  assign push_s       = cpu_we && !full_s;
  assign pop_s        = (state_q == REQ) && mem_ack;
  assign head_nx_s    = head_q + AW'(1'b1);
  assign store_addr_s = {cpu_addr[31:2], 2'b00};

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_nx_s;
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + AW'(1'b1);
    end else begin
      tail_d = tail_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Walk entries oldest to youngest so the last match wins regardless of wrap
  always_comb begin
    fwd_data_s = rd_data;
    idx_s      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx_s][31:2] == cpu_addr[31:2])) begin
        fwd_data_s = data_q[idx_s];
      end else begin
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Storage, pointers, sticky overflow and the drain FSM with its registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'h0000_0000;
        data_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        addr_q[tail_q] <= store_addr_s;
        data_q[tail_q] <= cpu_wdata;
      end
      overflow_q <= overflow_q | (cpu_we & full_s);
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= addr_q[head_q];
            mem_wdata_q <= data_q[head_q];
          end else if (push_s) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= store_addr_s;
            mem_wdata_q <= cpu_wdata;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (count_d == '0) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end else if (count_q > CW'(1'b1)) begin
              mem_addr_q  <= addr_q[head_nx_s];
              mem_wdata_q <= data_q[head_nx_s];
            end else begin
              // Only the entry pushed on this same edge remains; take it from the inputs
              mem_addr_q  <= store_addr_s;
              mem_wdata_q <= cpu_wdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdata = fwd_data_s;
  assign rd_addr   = cpu_addr;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = full_s;
  assign empty     = (count_q == '0) && !mem_req_q;
  assign overflow  = overflow_q;

endmodule
